// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Turns UART receiver byte completions into validated command frames
// (SOF, LEN, payload, checksum), buffers the payload until the checksum
// matches, then drains it downstream over a valid/ready stream.
//
// Ports:
//   system_clk    - single clock, rising edge
//   reset         - asynchronous active-high reset
//   rx_byte       - receiver data, stable while rx_complete is high
//   rx_complete   - receiver completion level (asynchronous, synchronized here)
//   rx_error_bit  - receiver status: 0 ok, 1 no data (ignored), 2 stop-bit error
//   frame_data    - payload byte at the drain pointer (0 outside DRAIN)
//   frame_valid   - frame_data is valid
//   frame_last    - current byte is the final payload byte
//   frame_ready   - downstream accepts on frame_valid & frame_ready
//   frame_done    - one-cycle pulse after the last byte is accepted
//   err_pulse     - one-cycle pulse on any error
//   err_code      - last error: 0 none, 1 BAD_LEN, 2 CSUM, 3 FRAMING, 4 TIMEOUT, 5 OVERRUN
//   frame_count   - frames fully drained, wraps at 16 bits
//   busy          - state is not IDLE
module uart_rx_frame_ctrl #(
   parameter logic [7:0] SOF            = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic        system_clk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_complete,
   input  logic [1:0]  rx_error_bit,
   output logic [7:0]  frame_data,
   output logic        frame_valid,
   output logic        frame_last,
   input  logic        frame_ready,
   output logic        frame_done,
   output logic        err_pulse,
   output logic [2:0]  err_code,
   output logic [15:0] frame_count,
   output logic        busy
);

   localparam int             AW        = $clog2(MAX_LEN);
   localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [2:0] E_BAD_LEN = 3'd1;
   localparam logic [2:0] E_CSUM    = 3'd2;
   localparam logic [2:0] E_FRAMING = 3'd3;
   localparam logic [2:0] E_TIMEOUT = 3'd4;
   localparam logic [2:0] E_OVERRUN = 3'd5;

   typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_DRAIN} state_t;

   state_t         state_reg, state_next;
   logic [2:0]     sync_reg;
   logic           stb_reg;
   logic [7:0]     byte_reg;
   logic [1:0]     errbit_reg;
   logic [7:0]     len_reg, len_next;
   logic [7:0]     csum_reg, csum_next;
   logic [7:0]     wr_idx_reg, wr_idx_next;
   logic [7:0]     rd_idx_reg, rd_idx_next;
   logic [TW-1:0]  tmo_reg, tmo_next;
   logic           err_pulse_reg, err_pulse_next;
   logic [2:0]     err_code_reg, err_code_next;
   logic           done_reg, done_next;
   logic [15:0]    count_reg, count_next;
   logic           mem_we;
   logic [7:0]     rd_data_reg;
   logic [7:0]     mem [0:(1<<AW)-1];

   // A strobe carrying status 1 (no data) is not a byte at all.
   logic byte_ok, stop_err;
   assign byte_ok  = stb_reg && (errbit_reg != 2'd1);
   assign stop_err = stb_reg && (errbit_reg == 2'd2);

   // Synchronizer stages 0/1, stage 2 remembers the previous level for
   // edge detection. The strobe is registered together with the data so
   // byte_reg/errbit_reg are valid exactly while stb_reg is high.
   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         sync_reg      <= '0;
         stb_reg       <= 1'b0;
         byte_reg      <= '0;
         errbit_reg    <= '0;
         state_reg     <= ST_IDLE;
         len_reg       <= '0;
         csum_reg      <= '0;
         wr_idx_reg    <= '0;
         rd_idx_reg    <= '0;
         tmo_reg       <= '0;
         err_pulse_reg <= 1'b0;
         err_code_reg  <= '0;
         done_reg      <= 1'b0;
         count_reg     <= '0;
      end else begin
         sync_reg <= {sync_reg[1:0], rx_complete};
         stb_reg  <= sync_reg[1] & ~sync_reg[2];
         if (sync_reg[1] & ~sync_reg[2]) begin
            byte_reg   <= rx_byte;
            errbit_reg <= rx_error_bit;
         end
         state_reg     <= state_next;
         len_reg       <= len_next;
         csum_reg      <= csum_next;
         wr_idx_reg    <= wr_idx_next;
         rd_idx_reg    <= rd_idx_next;
         tmo_reg       <= tmo_next;
         err_pulse_reg <= err_pulse_next;
         err_code_reg  <= err_code_next;
         done_reg      <= done_next;
         count_reg     <= count_next;
      end
   end

   // Payload buffer. The read address is the next drain index so the
   // registered read already presents the right byte on DRAIN entry and
   // keeps up with one handshake per cycle.
   always_ff @(posedge system_clk) begin
      if (mem_we)
         mem[wr_idx_reg[AW-1:0]] <= byte_reg;
      rd_data_reg <= mem[rd_idx_next[AW-1:0]];
   end

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      csum_next      = csum_reg;
      wr_idx_next    = wr_idx_reg;
      rd_idx_next    = rd_idx_reg;
      tmo_next       = tmo_reg;
      err_pulse_next = 1'b0;
      err_code_next  = err_code_reg;
      done_next      = 1'b0;
      count_next     = count_reg;
      mem_we         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            tmo_next = '0;
            if (stop_err) begin
               err_pulse_next = 1'b1;
               err_code_next  = E_FRAMING;
            end else if (byte_ok && byte_reg == SOF) begin
               state_next = ST_LEN;
            end
         end

         ST_LEN, ST_PAYLOAD, ST_CSUM: begin
            if (stop_err) begin
               err_pulse_next = 1'b1;
               err_code_next  = E_FRAMING;
               state_next     = ST_IDLE;
               tmo_next       = '0;
            end else if (byte_ok) begin
               // An arriving byte always beats a coinciding timeout.
               tmo_next = '0;
               case (state_reg)
                  ST_LEN: begin
                     if (byte_reg != 8'd0 && byte_reg <= MAX_LEN_B) begin
                        len_next    = byte_reg;
                        csum_next   = byte_reg;
                        wr_idx_next = '0;
                        state_next  = ST_PAYLOAD;
                     end else begin
                        err_pulse_next = 1'b1;
                        err_code_next  = E_BAD_LEN;
                        state_next     = ST_IDLE;
                     end
                  end
                  ST_PAYLOAD: begin
                     mem_we      = 1'b1;
                     csum_next   = csum_reg + byte_reg;
                     wr_idx_next = wr_idx_reg + 8'd1;
                     if (wr_idx_reg == len_reg - 8'd1)
                        state_next = ST_CSUM;
                  end
                  default: begin
                     if (byte_reg == csum_reg) begin
                        rd_idx_next = '0;
                        state_next  = ST_DRAIN;
                     end else begin
                        err_pulse_next = 1'b1;
                        err_code_next  = E_CSUM;
                        state_next     = ST_IDLE;
                     end
                  end
               endcase
            end else if (tmo_reg == TMO_LAST) begin
               err_pulse_next = 1'b1;
               err_code_next  = E_TIMEOUT;
               state_next     = ST_IDLE;
               tmo_next       = '0;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end

         ST_DRAIN: begin
            tmo_next = '0;
            // Overrun drops the byte; the drain itself is unaffected.
            if (byte_ok) begin
               err_pulse_next = 1'b1;
               err_code_next  = E_OVERRUN;
            end
            if (frame_ready) begin
               if (rd_idx_reg == len_reg - 8'd1) begin
                  done_next   = 1'b1;
                  count_next  = count_reg + 16'd1;
                  rd_idx_next = '0;
                  state_next  = ST_IDLE;
               end else begin
                  rd_idx_next = rd_idx_reg + 8'd1;
               end
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   assign frame_valid = (state_reg == ST_DRAIN);
   assign frame_data  = frame_valid ? rd_data_reg : 8'd0;
   assign frame_last  = frame_valid && (rd_idx_reg == len_reg - 8'd1);
   assign frame_done  = done_reg;
   assign err_pulse   = err_pulse_reg;
   assign err_code    = err_code_reg;
   assign frame_count = count_reg;
   assign busy        = (state_reg != ST_IDLE);

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame-level controller that sits behind the UART receiver in the `system_clk` domain. It turns the receiver's per-byte completion strobes into validated command frames (SOF, LEN, payload, checksum) and buffers each payload until its checksum passes. It then drains the payload to the downstream command logic over a valid/ready stream and reports framing, length, checksum, timeout and overrun errors.

## Interface
- `SOF`, 8'hA5, start-of-frame byte value
- `MAX_LEN`, 16, maximum payload length in bytes (2..255)
- `TIMEOUT_CYCLES`, 100000, allowed `system_clk` cycles between bytes inside a frame
- `system_clk`  in  1  single clock; all logic is on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rx_byte`  in  8  receiver data; stable while `rx_complete` is high
- `rx_complete`  in  1  receiver completion level, asynchronous to `system_clk`; high for at least 2 `system_clk` cycles per byte
- `rx_error_bit`  in  2  receiver status: 0 = success, 1 = no data (ignored), 2 = stop-bit error
- `frame_data`  out  8  payload byte at the drain pointer
- `frame_valid`  out  1  `frame_data` is valid
- `frame_last`  out  1  the current byte is the final payload byte
- `frame_ready`  in  1  downstream accepts the byte when `frame_valid & frame_ready`
- `frame_done`  out  1  one-cycle pulse when the last byte is accepted
- `err_pulse`  out  1  one-cycle pulse on any error
- `err_code`  out  3  last error: 0 none, 1 BAD_LEN, 2 CSUM, 3 FRAMING, 4 TIMEOUT, 5 OVERRUN
- `frame_count`  out  16  count of frames fully drained; wraps from 16'hFFFF to 0
- `busy`  out  1  state is not IDLE

## Operation
- Byte strobe: `rx_complete` passes through a 2-flop synchronizer. A rising edge on the synchronized level produces `byte_stb` for one cycle. `rx_byte` and `rx_error_bit` are captured on `byte_stb`.
- Any `byte_stb` with `rx_error_bit == 2` in IDLE/LEN/PAYLOAD/CSUM triggers FRAMING: the byte is discarded and the state goes to IDLE.
- States and transitions:
  - IDLE: a byte equal to `SOF` moves to LEN. Any other byte is silently discarded.
  - LEN: a byte value of 1..MAX_LEN is stored as `len` and `csum` is set to that byte; the state moves to PAYLOAD. A value of 0 or greater than MAX_LEN triggers BAD_LEN and returns to IDLE.
  - PAYLOAD: each byte is written to `buf[wr_idx]`, `csum <= csum + byte` (8-bit, mod 256) and `wr_idx` increments. The byte written at `wr_idx == len-1` moves the state to CSUM.
  - CSUM: a byte equal to `csum` moves to DRAIN with `rd_idx = 0`. A mismatch triggers CSUM and returns to IDLE.
  - DRAIN: `frame_valid = 1` and `frame_data = buf[rd_idx]`.
    - Each handshake increments `rd_idx`.
    - `frame_last = (rd_idx == len-1)`.
    - The handshake on the last byte pulses `frame_done`, increments `frame_count` and returns to IDLE.
    - A `byte_stb` in DRAIN triggers OVERRUN. The byte is dropped and the drain continues undisturbed.
- Timeout: a counter runs in LEN/PAYLOAD/CSUM, clears on every `byte_stb` and on state entry, and does not run in IDLE/DRAIN. Reaching TIMEOUT_CYCLES-1 triggers TIMEOUT and returns to IDLE.
- Error handling: `err_pulse` is high for exactly one cycle and `err_code` is updated in the same cycle. `err_code` holds its value until the next error.
- Simultaneous events:
  - If `byte_stb` coincides with timeout expiry, the byte wins and the timeout is cleared.
  - In DRAIN, a last-byte handshake in the same cycle as an overrun produces both `frame_done` and `err_pulse`.
- `frame_valid`, `frame_last` and `frame_data` are 0 outside DRAIN.

## Timing
- Reset values: state IDLE, all outputs 0, counters and indices 0, synchronizer flops 0. The buffer contents are don't-care.
- Reset can arrive mid-frame or mid-drain. It aborts the operation immediately, with no `frame_done` and no `err_pulse`.
- Latency: a `rx_complete` rise sampled at edge n gives `byte_stb` high in cycle n+2. The resulting state and output changes are visible at n+3.
- The first `frame_valid` appears the cycle after the checksum byte's `byte_stb`.
- Drain throughput is 1 byte/cycle with `frame_ready` held high. A len-L frame drains in L cycles.
- `frame_data` and `frame_last` must stay stable while `frame_valid & !frame_ready`.

## Test plan
- Good frame: bytes A5 03 11 22 33 69 with `frame_ready` = 1 -> `frame_data` 11, 22, 33 on consecutive cycles; `frame_last` with 33; `frame_done` pulse; `frame_count` = 1; `err_code` = 0.
- Checksum and length errors: A5 03 11 22 33 6A -> `err_code` = 2, no `frame_valid`. A5 00 -> `err_code` = 1. A5 11 (17 > MAX_LEN) -> `err_code` = 1. Next, A5 01 7F 80 -> one-byte frame 7F drains correctly.
- Timeout: A5 02 44, then no bytes for TIMEOUT_CYCLES -> `err_pulse` with `err_code` = 4 and `busy` = 0. The bytes 55 66 that follow are discarded in IDLE.
- Overrun and backpressure: good frame A5 02 01 02 05 with `frame_ready` = 0, then a byte 99 arrives -> `err_code` = 5; data 01, 02 stay held. Releasing ready drains 01, 02 and `frame_count` increments.
- Stop-bit error: A5 02 AA with `rx_error_bit` = 2 -> `err_code` = 3, return to IDLE, no output.
- Reset mid-PAYLOAD and mid-DRAIN -> outputs return to 0 asynchronously with no pulses. `frame_count` = 0. The next good frame is received normally.
